// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor controller.
//   state_t  - controller state encoding (IDLE / RUN / DONE)
//   STATE_W  - width of the state encoding
package serial_sub_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if: operand/result handshake bundle for serial_sub_ctrl.
//   in_valid/in_ready/a/b          operand side (producer -> block)
//   out_valid/out_ready/diff/borrow_out  result side (block -> consumer)
//   busy                           block is stepping through the bits
// Modports: master = producer/consumer side, slave = the subtractor block.
interface serial_sub_ctrl_if #(
   parameter int unsigned W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow_out, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow_out, busy
   );
endinterface

// File: rtl/serial_sub_ctrl_fs_cell.sv
// fs_cell: 1-bit full subtractor, d = x - y - bin.
//   x, y  operand bits      bin   borrow in
//   d     difference bit    bout  borrow out
// Two half-subtract stages; the borrows of both stages are ORed.
module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1;
   logic b1;
   logic b2;

   // first half-subtract: x - y
   assign d1 = x ^ y;
   assign b1 = ~x & y;

   // second half-subtract: d1 - bin
   assign d  = d1 ^ bin;
   assign b2 = ~d1 & bin;

   assign bout = b1 | b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial W-bit unsigned subtractor, diff = a - b,
// one bit per clock LSB first through a single fs_cell.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_sub_ctrl_if.slave: in_valid/in_ready/a/b operand handshake,
//          out_valid/out_ready/diff/borrow_out result handshake, busy.
// Optional build macro SERIAL_SUB_SAT_EN: a negative result (final borrow)
// saturates diff to 0; borrow_out still reports the borrow.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic clk,
   input  logic rst_n,
   serial_sub_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(W);

   state_t        state;
   state_t        state_nxt;

   logic [W-1:0]  a_sr;
   logic [W-1:0]  b_sr;
   logic [W-1:0]  res_sr;
   logic          bflop;
   logic [CW-1:0] count;
   logic [W-1:0]  diff_q;
   logic          borrow_q;

   logic          load;
   logic          step;
   logic          finish;
   logic          cell_d;
   logic          cell_b;
   logic [W-1:0]  res_nxt;

   fs_cell u_cell (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (bflop),
      .d    (cell_d),
      .bout (cell_b)
   );

   // result register with the current bit shifted in at the MSB
   assign res_nxt = {cell_d, res_sr[W-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            // last of the W bit steps happens on this edge
            if (count == CW'(W - 1)) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         bflop    <= 1'b0;
         count    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         if (load) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            bflop <= 1'b0;
            count <= '0;
         end
         if (step) begin
            a_sr   <= {1'b0, a_sr[W-1:1]};
            b_sr   <= {1'b0, b_sr[W-1:1]};
            res_sr <= res_nxt;
            bflop  <= cell_b;
            count  <= count + CW'(1);
         end
         // outputs take the completed result on entry to DONE and hold it
         if (finish) begin
`ifdef SERIAL_SUB_SAT_EN
            diff_q <= cell_b ? '0 : res_nxt;
`else
            diff_q <= res_nxt;
`endif
            borrow_q <= cell_b;
         end
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.busy       = (state == RUN);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for serial_sub_ctrl (W=8).
// Driver pushes hand-computed results on accept; monitor pops on each
// out_valid&out_ready handshake and checks result and latency.
// Honours SERIAL_SUB_SAT_EN for the expected diff on borrow.
module tb_serial_sub_ctrl;
   localparam int unsigned W = 8;
`ifdef SERIAL_SUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] d;
      logic         b;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   serial_sub_ctrl_if #(.W(W)) bus ();

   serial_sub_ctrl #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
   endtask

   function automatic logic [W-1:0] sat_d(input logic [W-1:0] raw, input logic br);
      return (SAT && br) ? '0 : raw;
   endfunction

   // call at a negedge; returns at the negedge after the accept edge
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] raw, input logic br);
      int unsigned n = 0;
      exp_t e;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         fail_now("accept");
         bus.in_valid = 1'b0;
         return;
      end
      e.d   = sat_d(raw, br);
      e.b   = br;
      e.acc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         fail_now("drain");
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] raw, input logic br);
      issue(a, b, raw, br);
      drain();
   endtask

   // monitor: sample 1 time unit after the falling edge
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            prev = 1'b0;
            continue;
         end
         if (bus.out_valid && !prev) begin
            if (q.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               chk("latency", 32'(cyc - q[0].acc), 32'(W));
            end
         end
         if (bus.out_valid && bus.out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("diff", 32'(bus.diff), 32'(e.d));
            chk("borrow_out", 32'(bus.borrow_out), 32'(e.b));
         end
         prev = bus.out_valid;
      end
   end

   initial begin
      int unsigned n;
      logic [W-1:0] hd;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_diff", 32'(bus.diff), 32'd0);
      chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed vectors
      run_op(8'h5A, 8'h23, 8'h37, 1'b0);
      run_op(8'h23, 8'h5A, 8'hC9, 1'b1);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1);
      run_op(8'hFF, 8'hFF, 8'h00, 1'b0);
      run_op(8'h80, 8'h01, 8'h7F, 1'b0);
      run_op(8'h01, 8'h80, 8'h81, 1'b1);
      run_op(8'hFF, 8'h00, 8'hFF, 1'b0);
      run_op(8'h00, 8'hFF, 8'h01, 1'b1);

      // operands changing while in_valid stays high after accept
      issue(8'h5A, 8'h23, 8'h37, 1'b0);
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         bus.a = 8'($urandom);
         bus.b = 8'($urandom);
         @(negedge clk);
         n++;
      end
      bus.in_valid = 1'b0;
      if (!bus.out_valid) fail_now("t5_out_valid");
      drain();

      // consumer stalls for 5 cycles in DONE
      bus.out_ready = 1'b0;
      issue(8'h23, 8'h5A, 8'hC9, 1'b1);
      hd = sat_d(8'hC9, 1'b1);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) fail_now("t4_out_valid");
      for (int i = 0; i < 5; i++) begin
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         chk("hold_busy", 32'(bus.busy), 32'd0);
         chk("hold_diff", 32'(bus.diff), 32'(hd));
         chk("hold_borrow", 32'(bus.borrow_out), 32'd1);
         bus.in_valid = 1'b1;
         bus.a = 8'h11;
         bus.b = 8'h22;
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("post_hold_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_hold_out_valid", 32'(bus.out_valid), 32'd0);
      drain();

      // reset mid-RUN at count=3
      issue(8'h5A, 8'h23, 8'h37, 1'b0);
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_diff", 32'(bus.diff), 32'd0);
      chk("abort_borrow", 32'(bus.borrow_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 4) @(negedge clk);
      chk("after_rst_in_ready", 32'(bus.in_ready), 32'd1);
      run_op(8'h5A, 8'h23, 8'h37, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
